// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: PC + payload, ready/valid handshake, 2-entry skid, freeze and flush.
// Define PIPE_REG_PERF_EN to add saturating stall_count / flush_count outputs.
module pipe_stage_reg #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   PC_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [DATA_WIDTH-1:0] data
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // ready/valid depend only on freeze and occupancy, never on the partner's signal.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e state, state_next;

  logic [PC_WIDTH-1:0]   main_pc, main_pc_next;
  logic [DATA_WIDTH-1:0] main_data, main_data_next;
  logic [PC_WIDTH-1:0]   skid_pc, skid_pc_next;
  logic [DATA_WIDTH-1:0] skid_data, skid_data_next;
  logic                  in_fire, out_fire;

  assign in_ready  = !freeze && (state != FULL);
  assign out_valid = !freeze && (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign PC        = main_pc;
  assign data      = main_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_data <= '0;
      skid_pc   <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_next;
      main_pc   <= main_pc_next;
      main_data <= main_data_next;
      skid_pc   <= skid_pc_next;
      skid_data <= skid_data_next;
    end
  end

  // Freeze needs no branch: it forces both fires low, so everything holds.
  always_comb begin
    state_next     = state;
    main_pc_next   = main_pc;
    main_data_next = main_data;
    skid_pc_next   = skid_pc;
    skid_data_next = skid_data;
    if (flush) begin
      state_next     = EMPTY;
      main_pc_next   = '0;
      main_data_next = '0;
      skid_pc_next   = '0;
      skid_data_next = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_pc_next   = PC_in;
            main_data_next = data_in;
            state_next     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_pc_next   = PC_in;
            main_data_next = data_in;
          end else if (out_fire) begin
            state_next = EMPTY;
          end else if (in_fire) begin
            skid_pc_next   = PC_in;
            skid_data_next = data_in;
            state_next     = FULL;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_pc_next   = skid_pc;
            main_data_next = skid_data;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

`ifdef PIPE_REG_PERF_EN
  logic stall_cycle, flush_cycle;
  assign stall_cycle = (state != EMPTY) && (freeze || !out_ready);
  assign flush_cycle = (state != EMPTY) && flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_cycle && (stall_count != {CNT_WIDTH{1'b1}}))
        stall_count <= stall_count + 1'b1;
      if (flush_cycle && (flush_count != {CNT_WIDTH{1'b1}}))
        flush_count <= flush_count + 1'b1;
    end
  end
`else
  logic [CNT_WIDTH-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: occupancy model + expected queue checked every negedge.
module tb_pipe_stage_reg;
  localparam int PW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          freeze = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] PC_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] PC;
  logic [DW-1:0] data;
`ifdef PIPE_REG_PERF_EN
  logic [CW-1:0] stall_count, flush_count;
`endif

  pipe_stage_reg #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .PC_in(PC_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .PC(PC), .data(data)
`ifdef PIPE_REG_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;

  logic [PW+DW-1:0] exp_q[$];
  int               m_cnt = 0;
  logic             cleared = 1'b1;
  logic [CW-1:0]    m_stall = '0;
  logic [CW-1:0]    m_flush = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // driver: apply one cycle of inputs, return 1 time unit after the edge
  task automatic cycle(input logic iv, input logic [PW-1:0] pc, input logic [DW-1:0] d,
                       input logic ordy, input logic frz, input logic fl);
    in_valid  = iv;
    PC_in     = pc;
    data_in   = d;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // scoreboard / model
  always @(negedge clk) begin
    logic exp_ir, exp_ov, ifire, ofire;
    if (mon_en) begin
      exp_ir = !freeze && (m_cnt != 2);
      exp_ov = !freeze && (m_cnt != 0);
      check("in_ready", 64'(in_ready), 64'(exp_ir));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      if (m_cnt != 0) check("head", {PC, data}, exp_q[0]);
      else if (cleared) check("empty_zero", {PC, data}, 64'd0);
`ifdef PIPE_REG_PERF_EN
      check("stall_count", 64'(stall_count), 64'(m_stall));
      check("flush_count", 64'(flush_count), 64'(m_flush));
`endif
      if (rst) begin
        m_cnt = 0;
        exp_q.delete();
        cleared = 1'b1;
        m_stall = '0;
        m_flush = '0;
      end else begin
        if (m_cnt != 0 && (freeze || !out_ready) && m_stall != '1) m_stall = m_stall + 1'b1;
        if (m_cnt != 0 && flush && m_flush != '1) m_flush = m_flush + 1'b1;
        if (flush) begin
          m_cnt = 0;
          exp_q.delete();
          cleared = 1'b1;
        end else begin
          ofire = exp_ov && out_ready;
          ifire = in_valid && exp_ir;
          if (ofire) begin
            if (exp_q.size() == 0) check("pop_empty", 64'd1, 64'd0);
            else void'(exp_q.pop_front());
            m_cnt--;
          end
          if (ifire) begin
            exp_q.push_back({PC_in, data_in});
            cleared = 1'b0;
            m_cnt++;
          end
        end
      end
    end
  end

  initial begin
    // reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pc_data", {PC, data}, 64'd0);
    mon_en = 1'b1;

    // stream with out_ready high
    cycle(1, 32'h0, 32'h11, 1, 0, 0);
    check("stream_first", {PC, data, 1'b0} >> 1, {32'h0, 32'h11});
    check("stream_valid", 64'(out_valid), 64'd1);
    cycle(1, 32'h4, 32'h22, 1, 0, 0);
    cycle(1, 32'h8, 32'h33, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // back-pressure: third entry refused until the skid drains
    cycle(1, 32'h0, 32'h11, 0, 0, 0);
    cycle(1, 32'h4, 32'h22, 0, 0, 0);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    cycle(1, 32'h8, 32'h33, 0, 0, 0);
    cycle(1, 32'h8, 32'h33, 1, 0, 0);
    cycle(1, 32'h8, 32'h33, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // freeze while FULL
    cycle(1, 32'h0, 32'h11, 0, 0, 0);
    cycle(1, 32'h4, 32'h22, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'h8, 32'h33, 1, 1, 0);
    check("freeze_hold_pc", 64'(PC), 64'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);

    // flush while FULL with an incoming entry
    cycle(1, 32'h20, 32'h55, 0, 0, 0);
    cycle(1, 32'h24, 32'h66, 0, 0, 0);
    cycle(1, 32'hC, 32'h44, 0, 0, 1);
    check("flush_pc_data", {PC, data}, 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    cycle(0, 0, 0, 1, 0, 0);

    // reset while FULL and frozen
    cycle(1, 32'h100, 32'hA, 0, 0, 0);
    cycle(1, 32'h104, 32'hB, 0, 0, 0);
    rst = 1'b1;
    cycle(0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    check("rstmid_pc_data", {PC, data}, 64'd0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 24) == 0));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);

    // stall saturation and flush counting
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle(1, 32'h40, 32'h77, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0);
`ifdef PIPE_REG_PERF_EN
    check("stall_sat", 64'(stall_count), 64'hF);
`endif
    cycle(0, 0, 0, 0, 0, 1);
`ifdef PIPE_REG_PERF_EN
    check("flush_one", 64'(flush_count), 64'd1);
`endif
    cycle(0, 0, 0, 0, 0, 1);
`ifdef PIPE_REG_PERF_EN
    check("flush_empty", 64'(flush_count), 64'd1);
`endif
    cycle(0, 0, 0, 1, 0, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
